// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    // Scanner control states.
    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        WAIT_RELEASE
    } state_e;

    // Classification of one complete scan of the matrix.
    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } result_e;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned CODE_W = 4;

    // Auto-repeat timing, in full scans.
    localparam int unsigned REPEAT_FIRST = 125;
    localparam int unsigned REPEAT_NEXT  = 25;

    // Hex code for each matrix position, indexed by row*4 + col.
    localparam logic [CODE_W-1:0] KEYMAP [ROWS*COLS] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

endpackage

// File: rtl/keypad_hit_decode.sv
// Reduces a full-scan hit vector to a result kind and the hex code of a single key.
module keypad_hit_decode
    import keypad_pkg::*;
(
    input  logic [ROWS*COLS-1:0] hit,
    output result_e              kind_c,
    output logic [CODE_W-1:0]    code_c
);

    logic [4:0] ones;
    logic [3:0] idx;

    // Count set bits and remember the position of the last one seen.
    always_comb begin
        ones   = '0;
        idx    = '0;
        kind_c = NONE;
        code_c = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (hit[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end
        if (ones == 5'd1) begin
            kind_c = KEY;
            code_c = KEYMAP[idx];
        end else if (ones > 5'd1) begin
            kind_c = MULTI;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, debounce, ghost
// rejection and a 16-bit hex entry register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] value
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned STB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_TARGET = STB_W'(DEBOUNCE_SCANS);

    logic [3:0]        row_meta;
    logic [3:0]        row_sync;
    logic [DIV_W-1:0]  dwell;
    logic [1:0]        col_idx;
    logic [15:0]       hit;
    logic              scan_done;
    state_e            state;
    logic [3:0]        candidate;
    logic [STB_W-1:0]  stable;
    result_e           kind;
    logic [3:0]        code;
`ifdef KEYPAD_REPEAT_EN
    logic [6:0]        rep_cnt;
    logic              rep_armed;
`endif

    // Two-flop synchronizer for the asynchronous row inputs; idle rows read high.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Column dwell timing: capture rows at the end of each dwell, then step the column.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            dwell     <= '0;
            col_idx   <= '0;
            col_out   <= 4'b1110;
            hit       <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (dwell == DIV_LAST) begin
                dwell <= '0;
                for (int r = 0; r < 4; r++) begin
                    hit[{2'(r), col_idx}] <= ~row_sync[r];
                end
                col_idx   <= col_idx + 2'd1;
                col_out   <= {col_out[2:0], col_out[3]};
                scan_done <= (col_idx == 2'd3);
            end else begin
                dwell <= dwell + DIV_W'(1);
            end
        end
    end

    keypad_hit_decode u_decode (
        .hit    (hit),
        .kind_c (kind),
        .code_c (code)
    );

    // Press/release debounce FSM, stepped once per completed scan.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state     <= IDLE;
            candidate <= '0;
            stable    <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
            value     <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_done && kind == KEY) begin
                        candidate <= code;
                        stable    <= STB_W'(1);
                        state     <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (scan_done) begin
                        if (kind == KEY && code == candidate) begin
                            stable <= stable + STB_W'(1);
                            if ((stable + STB_W'(1)) == STB_TARGET) begin
                                key_valid <= 1'b1;
                                key_code  <= candidate;
                                value     <= {value[11:0], candidate};
                                key_held  <= 1'b1;
                                state     <= PRESSED;
                            end
                        end else if (kind == KEY) begin
                            candidate <= code;
                            stable    <= STB_W'(1);
                        end else begin
                            stable <= '0;
                            state  <= IDLE;
                        end
                    end
                end
                PRESSED: begin
                    stable <= '0;
                    state  <= WAIT_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt   <= '0;
                    rep_armed <= 1'b0;
`endif
                end
                WAIT_RELEASE: begin
                    if (scan_done) begin
                        if (kind == NONE) begin
                            if ((stable + STB_W'(1)) == STB_TARGET) begin
                                stable   <= '0;
                                key_held <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                stable <= stable + STB_W'(1);
                            end
                        end else begin
                            stable <= '0;
                        end
`ifdef KEYPAD_REPEAT_EN
                        if (kind == KEY && code == candidate) begin
                            if ((rep_cnt + 7'd1) == (rep_armed ? 7'(REPEAT_NEXT) : 7'(REPEAT_FIRST))) begin
                                key_valid <= 1'b1;
                                key_code  <= candidate;
                                value     <= {value[11:0], candidate};
                                rep_cnt   <= '0;
                                rep_armed <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + 7'd1;
                            end
                        end else begin
                            rep_cnt   <= '0;
                            rep_armed <= 1'b0;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 8;
    localparam int unsigned SCAN_CYC = 4 * SCAN_DIV;

    logic        clk_100mhz = 1'b0;
    logic        reset      = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] value;

    logic [3:0]  keys [4];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses  = 0;
    int          p0;
    logic        col_chk_on = 1'b0;
    logic [3:0]  exp_col;
    int          exp_cnt;

    always #5 clk_100mhz = ~clk_100mhz;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_held   (key_held),
        .value      (value)
    );

    // Keypad model: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (keys[r][c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference column rotation: one step every SCAN_DIV cycles from reset.
    always @(posedge clk_100mhz) begin
        if (reset) begin
            exp_col <= 4'b1110;
            exp_cnt <= 0;
        end else if (exp_cnt == int'(SCAN_DIV) - 1) begin
            exp_cnt <= 0;
            exp_col <= {exp_col[2:0], exp_col[3]};
        end else begin
            exp_cnt <= exp_cnt + 1;
        end
    end

    // Per-cycle column checks and key_valid pulse counting.
    always @(negedge clk_100mhz) begin
        if (col_chk_on) begin
            check("col_one_low", 16'($countones(~col_out)), 16'd1);
            check("col_rotate", {12'd0, col_out}, {12'd0, exp_col});
            if (key_valid) pulses++;
        end
    end

    task automatic scans(input int n);
        repeat (n * SCAN_CYC) @(negedge clk_100mhz);
    endtask

    // Wait until the scan has just wrapped back to column 0.
    task automatic align();
        logic [3:0] last;
        int t;
        t    = 0;
        last = col_out;
        forever begin
            @(negedge clk_100mhz);
            t++;
            if (col_out == 4'b1110 && last != 4'b1110) break;
            last = col_out;
            if (t > 4 * SCAN_CYC) begin
                check("align_timeout", 16'd1, 16'd0);
                break;
            end
        end
    endtask

    task automatic tap(input int r, input int c, input int down, input int up);
        align();
        keys[r][c] = 1'b1;
        scans(down);
        keys[r][c] = 1'b0;
        scans(up);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
    endtask

    initial begin
        release_all();
        reset = 1'b1;
        repeat (3) @(negedge clk_100mhz);
        check("rst_col_out", {12'd0, col_out}, 16'h000E);
        check("rst_key_valid", {15'd0, key_valid}, 16'd0);
        check("rst_key_code", {12'd0, key_code}, 16'd0);
        check("rst_key_held", {15'd0, key_held}, 16'd0);
        check("rst_value", value, 16'h0000);
        col_chk_on = 1'b1;
        reset      = 1'b0;

        // Single press of '5', then release.
        p0 = pulses;
        align();
        keys[1][1] = 1'b1;
        scans(10);
        check("k5_pulses", 16'(pulses - p0), 16'd1);
        check("k5_code", {12'd0, key_code}, 16'h0005);
        check("k5_value", value, 16'h0005);
        check("k5_held", {15'd0, key_held}, 16'd1);
        keys[1][1] = 1'b0;
        repeat (120) @(negedge clk_100mhz);
        check("k5_held_before_rel", {15'd0, key_held}, 16'd1);
        repeat (16) @(negedge clk_100mhz);
        check("k5_held_after_rel", {15'd0, key_held}, 16'd0);
        scans(2);

        // Sequence 1, 2, A, F then 3 to wrap the entry register.
        p0 = pulses;
        tap(0, 0, 6, 6);
        tap(0, 1, 6, 6);
        tap(0, 3, 6, 6);
        tap(3, 1, 6, 6);
        check("seq_pulses", 16'(pulses - p0), 16'd4);
        check("seq_value", value, 16'h12AF);
        check("seq_code", {12'd0, key_code}, 16'h000F);
        p0 = pulses;
        tap(0, 2, 6, 6);
        check("wrap_pulses", 16'(pulses - p0), 16'd1);
        check("wrap_value", value, 16'h2AF3);
        check("wrap_code", {12'd0, key_code}, 16'h0003);

        // Ghost: '7' and '9' together must be rejected.
        p0 = pulses;
        align();
        keys[2][0] = 1'b1;
        keys[2][2] = 1'b1;
        scans(10);
        check("multi_pulses", 16'(pulses - p0), 16'd0);
        check("multi_held", {15'd0, key_held}, 16'd0);
        check("multi_value", value, 16'h2AF3);
        release_all();
        scans(6);

        // Bouncing '8' must not be accepted; a steady press then is.
        p0 = pulses;
        align();
        keys[2][1] = 1'b1;
        scans(3);
        keys[2][1] = 1'b0;
        scans(1);
        keys[2][1] = 1'b1;
        scans(3);
        keys[2][1] = 1'b0;
        scans(6);
        check("bounce_pulses", 16'(pulses - p0), 16'd0);
        check("bounce_value", value, 16'h2AF3);
        p0 = pulses;
        tap(2, 1, 5, 6);
        check("steady8_pulses", 16'(pulses - p0), 16'd1);
        check("steady8_code", {12'd0, key_code}, 16'h0008);
        check("steady8_value", value, 16'hAF38);

        // Reset while '4' is held, then re-acceptance of the same key.
        p0 = pulses;
        align();
        keys[1][0] = 1'b1;
        scans(6);
        check("k4_pulses", 16'(pulses - p0), 16'd1);
        check("k4_value", value, 16'hF384);
        check("k4_held", {15'd0, key_held}, 16'd1);
        reset = 1'b1;
        @(negedge clk_100mhz);
        reset = 1'b0;
        check("mid_rst_col_out", {12'd0, col_out}, 16'h000E);
        check("mid_rst_key_valid", {15'd0, key_valid}, 16'd0);
        check("mid_rst_key_code", {12'd0, key_code}, 16'd0);
        check("mid_rst_key_held", {15'd0, key_held}, 16'd0);
        check("mid_rst_value", value, 16'h0000);
        p0 = pulses;
        scans(6);
        check("k4_again_pulses", 16'(pulses - p0), 16'd1);
        check("k4_again_value", value, 16'h0004);
        check("k4_again_code", {12'd0, key_code}, 16'h0004);
        release_all();
        scans(6);
        check("k4_release_held", {15'd0, key_held}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
